// File: rtl/acumulador_n_bits.sv
// Streaming N-bit accumulator: sums operand groups closed by in_last or MAX_OPS,
// reporting modular sum, sticky carry and operand count via valid/ready handshakes.
module acumulador_n_bits #(
    parameter int N       = 8,
    parameter int MAX_OPS = 16,
    localparam int CW     = $clog2(MAX_OPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_carry,
    output logic [CW-1:0] out_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACUM   = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  acc;
    logic          carry;
    logic [CW-1:0] count;

    logic          accept;
    logic          close;
    logic [N:0]    add;
    logic [N-1:0]  sum_nx;
    logic          carry_nx;
    logic [CW-1:0] count_nx;

    assign in_ready  = rst_n && (state != RESULT);
    assign out_valid = (state == RESULT);
    assign accept    = in_valid && in_ready;
    assign add       = {1'b0, acc} + {1'b0, in_data};

    always_comb begin
        sum_nx   = in_data;
        carry_nx = 1'b0;
        count_nx = CW'(1);
        if (state == ACUM) begin
            sum_nx   = add[N-1:0];
            carry_nx = carry | add[N];
            count_nx = count + CW'(1);
        end
    end

    // A group also closes silently when it reaches MAX_OPS operands.
    assign close = in_last ||
                   ((state == ACUM) && (count_nx == CW'(MAX_OPS)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            carry     <= 1'b0;
            count     <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE, ACUM: begin
                    if (accept) begin
                        acc   <= sum_nx;
                        carry <= carry_nx;
                        count <= count_nx;
                        state <= close ? RESULT : ACUM;
                        if (close) begin
                            out_sum   <= sum_nx;
                            out_carry <= carry_nx;
                            out_count <= count_nx;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
